// File: rtl/timed_mem_scanner_pkg.sv
// scan_pkg: shared types and defaults for the timed memory scanner.
//   scan_state_t          FSM state encoding used by the top
//   DEFAULT_INTERVAL_CYC  default scan step length in clk cycles (10 s at 100 MHz)
package scan_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    LATCH  = 3'd2,
    ARM    = 3'd3,
    WAIT   = 3'd4,
    PAUSED = 3'd5
  } scan_state_t;

  localparam int unsigned DEFAULT_INTERVAL_CYC = 32'd1_000_000_000;

endpackage : scan_pkg

// File: rtl/timed_mem_scanner_timer.sv
// interval_timer: counts clk cycles while not held and pulses 'expired' for one
// cycle when the count reaches INTERVAL_CYC-1.
//   clk      in  system clock
//   rst_n    in  synchronous active-low reset, clears the count
//   restart  in  forces the count to 0 on the next cycle
//   hold     in  freezes the count (and suppresses expired)
//   expired  out one-cycle pulse at count == INTERVAL_CYC-1
module interval_timer
  import scan_pkg::*;
#(
  parameter int unsigned INTERVAL_CYC = DEFAULT_INTERVAL_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic hold,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(INTERVAL_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INTERVAL_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(INTERVAL_CYC);

  logic [CNT_W-1:0] count_q;

  // The count parks one past the expiry value so expired fires exactly once
  // per restart, even if the timer is left running.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (restart) begin
      count_q <= '0;
    end else if (!hold && (count_q != CNT_DONE)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign expired = !restart && !hold && (count_q == CNT_LAST);

endmodule : interval_timer

// File: rtl/timed_mem_scanner.sv
// timed_mem_scanner: arms an interval timer, waits for expiry, reads the next
// memory word and presents it to the display path, then re-arms. Supports
// run, pause (toggle) and single-step while paused.
//   clk, rst_n       clock, synchronous active-low reset
//   start            pulse: (re)start the scan at address 0
//   pause            pulse: toggle run/paused
//   step             pulse: while paused, read the next address immediately
//   mem_rd_en        one-cycle read strobe, mem_addr valid with it
//   mem_rd_data      read data, valid the cycle after mem_rd_en
//   disp_data/addr   last word read and its address, held between updates
//   disp_valid       one-cycle pulse when disp_data/disp_addr update
//   busy, paused     status flags
module timed_mem_scanner
  import scan_pkg::*;
#(
  parameter int unsigned INTERVAL_CYC = DEFAULT_INTERVAL_CYC,
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned LAST_ADDR    = 2**ADDR_W - 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pause,
  input  logic              step,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] disp_data,
  output logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic              busy,
  output logic              paused
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(LAST_ADDR);

  scan_state_t       state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic              pend_q;     // pause seen during READ/LATCH
  logic              step_q;     // current read was a single step from PAUSED
  logic              mem_rd_en_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] disp_data_q;
  logic [ADDR_W-1:0] disp_addr_q;
  logic              disp_valid_q;
  logic              busy_q;
  logic              paused_q;
  logic              timer_restart;
  logic              timer_hold;
  logic              timer_expired;

  assign addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_W'(1);

  // The timer only runs in WAIT; leaving WAIT for PAUSED therefore freezes it.
  assign timer_restart = (state_q == ARM);
  assign timer_hold    = (state_q != WAIT);

  interval_timer #(
    .INTERVAL_CYC(INTERVAL_CYC)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(timer_restart),
    .hold   (timer_hold),
    .expired(timer_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      pend_q       <= 1'b0;
      step_q       <= 1'b0;
      mem_rd_en_q  <= 1'b0;
      mem_addr_q   <= '0;
      disp_data_q  <= '0;
      disp_addr_q  <= '0;
      disp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      paused_q     <= 1'b0;
    end else begin
      mem_rd_en_q  <= 1'b0;
      disp_valid_q <= 1'b0;
      if (start) begin
        state_q     <= READ;
        addr_q      <= '0;
        mem_addr_q  <= '0;
        mem_rd_en_q <= 1'b1;
        pend_q      <= 1'b0;
        step_q      <= 1'b0;
        busy_q      <= 1'b1;
        paused_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: ;
          READ: begin
            state_q <= LATCH;
            if (pause) pend_q <= ~pend_q;
          end
          LATCH: begin
            disp_data_q  <= mem_rd_data;
            disp_addr_q  <= addr_q;
            disp_valid_q <= 1'b1;
            pend_q       <= 1'b0;
            step_q       <= 1'b0;
            // A step read returns to PAUSED; a pending pause toggles that
            // destination, so pause during a step read resumes the run.
            if (step_q ^ pend_q ^ pause) begin
              state_q  <= PAUSED;
              paused_q <= 1'b1;
            end else begin
              state_q  <= ARM;
              paused_q <= 1'b0;
            end
          end
          ARM: begin
            if (pause) begin
              state_q  <= PAUSED;
              paused_q <= 1'b1;
            end else begin
              state_q <= WAIT;
            end
          end
          WAIT: begin
            if (pause) begin
              state_q  <= PAUSED;
              paused_q <= 1'b1;
            end else if (timer_expired) begin
              state_q     <= READ;
              addr_q      <= addr_d;
              mem_addr_q  <= addr_d;
              mem_rd_en_q <= 1'b1;
            end
          end
          PAUSED: begin
            if (pause) begin
              state_q  <= ARM;
              paused_q <= 1'b0;
            end else if (step) begin
              state_q     <= READ;
              addr_q      <= addr_d;
              mem_addr_q  <= addr_d;
              mem_rd_en_q <= 1'b1;
              step_q      <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign mem_rd_en  = mem_rd_en_q;
  assign mem_addr   = mem_addr_q;
  assign disp_data  = disp_data_q;
  assign disp_addr  = disp_addr_q;
  assign disp_valid = disp_valid_q;
  assign busy       = busy_q;
  assign paused     = paused_q;

endmodule : timed_mem_scanner

// File: tb/tb_timed_mem_scanner.sv
// Directed bench for timed_mem_scanner with INTERVAL_CYC=5, ADDR_W=2,
// LAST_ADDR=3 and memory word i = 8'hA0+i.
module tb_timed_mem_scanner;

  localparam int unsigned IVL = 5;
  localparam int unsigned PERIOD = IVL + 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       step = 1'b0;
  logic       mem_rd_en;
  logic [1:0] mem_addr;
  logic [7:0] mem_rd_data = '0;
  logic [7:0] disp_data;
  logic [1:0] disp_addr;
  logic       disp_valid;
  logic       busy;
  logic       paused;

  int unsigned checks = 0;
  int unsigned failures = 0;

  timed_mem_scanner #(
    .INTERVAL_CYC(IVL),
    .ADDR_W(2),
    .DATA_W(8),
    .LAST_ADDR(3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pause      (pause),
    .step       (step),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rd_data(mem_rd_data),
    .disp_data  (disp_data),
    .disp_addr  (disp_addr),
    .disp_valid (disp_valid),
    .busy       (busy),
    .paused     (paused)
  );

  always #5 clk = ~clk;

  // Synchronous memory: word i = A0+i, one cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= 8'hA0 + {6'd0, mem_addr};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_pause();
    pause = 1'b1; tick(); pause = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1; tick(); step = 1'b0;
  endtask

  // Ticks until disp_valid is seen (bounded); n = edges waited.
  task automatic wait_valid(input int unsigned max, output int unsigned n);
    n = 0;
    while (!disp_valid && n < max) begin
      tick();
      n++;
    end
  endtask

  function automatic logic [31:0] outs_vec();
    return {14'd0, busy, paused, mem_rd_en, disp_valid, disp_addr, mem_addr, disp_data};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned n;
    int unsigned cnt_v;
    int unsigned cnt_r;
    logic [1:0] exp_a;

    // 1. reset and first word
    repeat (3) tick();
    check("reset_outputs", outs_vec(), 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_outputs", outs_vec(), 32'd0);
    pause = 1'b1; step = 1'b1; tick(); pause = 1'b0; step = 1'b0;
    check("idle_ignores_pause_step", {busy, paused, mem_rd_en}, 3'b000);
    pulse_start();
    check("start_rd_en", {mem_rd_en, mem_addr, busy}, {1'b1, 2'd0, 1'b1});
    tick();
    check("read_strobe_one_cycle", mem_rd_en, 1'b0);
    tick();
    check("first_word", {disp_valid, disp_addr, disp_data}, {1'b1, 2'd0, 8'hA0});
    tick();
    check("disp_valid_pulse", disp_valid, 1'b0);
    check("disp_hold", {disp_addr, disp_data}, {2'd0, 8'hA0});

    // 2. free run: addresses 1,2,3,0 at PERIOD-cycle spacing
    for (int unsigned k = 1; k <= 4; k++) begin
      if (k > 1) tick();
      wait_valid(20, n);
      exp_a = 2'(k % 4);
      check("run_period", n + 1, (k == 1) ? PERIOD : PERIOD);
      check("run_word", {disp_valid, disp_addr, disp_data},
            {1'b1, exp_a, 8'hA0 + {6'd0, exp_a}});
    end

    // 3. pause mid-WAIT, hold 50 cycles, resume with a full interval
    repeat (3) tick();
    pulse_pause();
    check("paused_flag", {paused, busy}, 2'b11);
    cnt_v = 0; cnt_r = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (disp_valid) cnt_v++;
      if (mem_rd_en) cnt_r++;
    end
    check("pause_no_activity", {cnt_v[15:0], cnt_r[15:0]}, 32'd0);
    check("pause_held", paused, 1'b1);
    pulse_pause();
    check("unpaused_flag", paused, 1'b0);
    wait_valid(20, n);
    check("resume_latency", n, PERIOD);
    check("resume_word", {disp_addr, disp_data}, {2'd1, 8'hA1});

    // 4. single steps while paused, then pause+step together
    tick(); tick();
    pulse_pause();
    pulse_step();
    check("step1_read", {mem_rd_en, mem_addr}, {1'b1, 2'd2});
    wait_valid(10, n);
    check("step1_word", {disp_valid, disp_addr, disp_data, paused}, {1'b1, 2'd2, 8'hA2, 1'b1});
    tick();
    pulse_step();
    wait_valid(10, n);
    check("step2_word", {disp_valid, disp_addr, disp_data, paused}, {1'b1, 2'd3, 8'hA3, 1'b1});
    tick();
    check("step_stays_paused", paused, 1'b1);
    pause = 1'b1; step = 1'b1; tick(); pause = 1'b0; step = 1'b0;
    check("pause_wins_over_step", {paused, mem_rd_en}, 2'b00);
    wait_valid(20, n);
    check("wrap_after_unpause", {n[7:0], disp_addr, disp_data}, {8'(PERIOD), 2'd0, 8'hA0});

    // 5. start during WAIT at address 2 restarts at 0
    tick(); wait_valid(20, n);
    tick(); wait_valid(20, n);
    check("reached_addr2", disp_addr, 2'd2);
    repeat (3) tick();
    pulse_start();
    check("restart_read", {mem_rd_en, mem_addr}, {1'b1, 2'd0});
    wait_valid(2, n);
    check("restart_word", {disp_valid, disp_addr, disp_data}, {1'b1, 2'd0, 8'hA0});

    // pause arriving during READ is honoured after LATCH
    pulse_start();
    pulse_pause();
    wait_valid(4, n);
    check("pending_pause_word", {disp_valid, disp_addr}, {1'b1, 2'd0});
    tick();
    check("pending_pause_taken", paused, 1'b1);
    pulse_pause();

    // 6. reset during WAIT
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    check("reset_mid_wait", outs_vec(), 32'd0);
    rst_n = 1'b1;
    cnt_v = 0; cnt_r = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (disp_valid) cnt_v++;
      if (mem_rd_en) cnt_r++;
    end
    check("post_reset_quiet", {cnt_v[15:0], cnt_r[15:0], 15'd0, busy}, 48'd0);
    pulse_start();
    wait_valid(4, n);
    check("post_reset_start", {n[3:0], disp_addr, disp_data}, {4'd2, 2'd0, 8'hA0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_timed_mem_scanner
